// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the LED matrix scanner: register offsets,
// field positions, matrix geometry and a byte-strobe merge function.
package led_matrix_pkg;

  // Matrix geometry
  localparam int ROWS     = 4;
  localparam int COLS     = 8;
  localparam int BRIGHT_W = 4;
  localparam int ROW_W    = 2;
  localparam int PHASE_W  = 4;

  // Word offsets (iomem_addr[4:2])
  localparam logic [2:0] OFF_FRAME0 = 3'd0;
  localparam logic [2:0] OFF_FRAME1 = 3'd1;
  localparam logic [2:0] OFF_FRAME2 = 3'd2;
  localparam logic [2:0] OFF_FRAME3 = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  // Field positions
  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_PRESCALE_LSB  = 16;
  localparam int STATUS_ROW_LSB     = 0;
  localparam int STATUS_FRAME_LSB   = 16;

  // Merge write data into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Scan timebase: prescale counter producing PWM ticks, 16-step phase counter,
// row counter and frame counter. Everything but the frame count is cleared
// and held while disabled.
module led_scan_timer
  import led_matrix_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic [15:0]        prescale,
  output logic               tick,
  output logic [PHASE_W-1:0] phase,
  output logic [ROW_W-1:0]   row,
  output logic [15:0]        frame_count,
  output logic               row_start
);

  logic [15:0]        cnt_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic [ROW_W-1:0]   row_reg;
  logic [15:0]        frame_reg;

  // ">=" lets a prescale lowered below the running count tick immediately.
  assign tick        = enable && (cnt_reg >= prescale);
  // First cycle of phase 0 of a row visit (count has just reloaded).
  assign row_start   = enable && (phase_reg == '0) && (cnt_reg == '0);
  assign phase       = phase_reg;
  assign row         = row_reg;
  assign frame_count = frame_reg;

  // Prescale, phase, row and frame counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_reg   <= '0;
      phase_reg <= '0;
      row_reg   <= '0;
      frame_reg <= '0;
    end else if (!enable) begin
      cnt_reg   <= '0;
      phase_reg <= '0;
      row_reg   <= '0;
    end else if (tick) begin
      cnt_reg   <= '0;
      phase_reg <= phase_reg + 1'b1;
      if (phase_reg == '1) begin
        row_reg <= row_reg + 1'b1;
        if (row_reg == ROW_W'(ROWS - 1)) frame_reg <= frame_reg + 16'd1;
      end
    end else begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// iomem slave driving a 4x8 multiplexed LED matrix with 4-bit PWM per LED.
// Firmware fills four FRAME registers; the scan timer walks rows and phases,
// a per-row shadow copy prevents tearing, and row/column drives are registered.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter logic [7:0]  ADDR_HI      = 8'h04,
  parameter logic [15:0] PRESCALE_RST = 16'd47
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  output logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n
);

  logic [31:0]        frame_reg [ROWS];
  logic               enable_reg;
  logic [15:0]        prescale_reg;
  logic [31:0]        shadow_reg;
  logic               ready_reg;
  logic [31:0]        rdata_reg;
  logic [ROWS-1:0]    row_n_reg;
  logic [COLS-1:0]    col_n_reg;

  logic               tick;
  logic [PHASE_W-1:0] phase;
  logic [ROW_W-1:0]   row;
  logic [15:0]        frame_count;
  logic               row_start;

  logic               hit;
  logic               is_write;
  logic [2:0]         word;
  logic [31:0]        read_data;
  logic [COLS-1:0]    col_on;

  // Only address bits that select the region and the word are decoded.
  logic unused_ok;
  assign unused_ok = &{1'b0, iomem_addr[23:5], iomem_addr[1:0], tick};

  assign hit      = iomem_valid && !ready_reg && (iomem_addr[31:24] == ADDR_HI);
  assign is_write = |iomem_wstrb;
  assign word     = iomem_addr[4:2];

  assign iomem_ready = ready_reg;
  assign iomem_rdata = rdata_reg;
  assign row_n       = row_n_reg;
  assign col_n       = col_n_reg;

  led_scan_timer u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable_reg),
    .prescale    (prescale_reg),
    .tick        (tick),
    .phase       (phase),
    .row         (row),
    .frame_count (frame_count),
    .row_start   (row_start)
  );

  // Register read multiplexer.
  always_comb begin
    read_data = '0;
    case (word)
      OFF_FRAME0, OFF_FRAME1, OFF_FRAME2, OFF_FRAME3:
        read_data = frame_reg[word[1:0]];
      OFF_CTRL: begin
        read_data[CTRL_ENABLE_BIT]                  = enable_reg;
        read_data[CTRL_PRESCALE_LSB +: 16]          = prescale_reg;
      end
      OFF_STATUS: begin
        read_data[STATUS_ROW_LSB +: ROW_W]          = row;
        read_data[STATUS_FRAME_LSB +: 16]           = frame_count;
      end
      default: read_data = '0;
    endcase
  end

  // Bus handshake: one-cycle ready with registered read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ready_reg <= hit;
      if (hit) rdata_reg <= read_data;
    end
  end

  // Frame buffer and CTRL writes, honouring byte strobes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < ROWS; i++) frame_reg[i] <= '0;
      enable_reg   <= 1'b0;
      prescale_reg <= PRESCALE_RST;
    end else if (hit && is_write) begin
      if (!word[2]) begin
        frame_reg[word[1:0]] <= apply_wstrb(frame_reg[word[1:0]], iomem_wdata, iomem_wstrb);
      end else if (word == OFF_CTRL) begin
        if (iomem_wstrb[0]) enable_reg <= iomem_wdata[CTRL_ENABLE_BIT];
        if (iomem_wstrb[2]) prescale_reg[7:0]  <= iomem_wdata[23:16];
        if (iomem_wstrb[3]) prescale_reg[15:8] <= iomem_wdata[31:24];
      end
    end
  end

  // Snapshot the row's frame word at the start of each row visit.
  always_ff @(posedge clk) begin
    if (!resetn) shadow_reg <= '0;
    else if (row_start) shadow_reg <= frame_reg[row];
  end

  // Per-column PWM compare; phase 0 is dead time for anti-ghosting.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign col_on[gi] = (phase != '0) &&
                          (phase <= shadow_reg[gi*BRIGHT_W +: BRIGHT_W]);
    end
  endgenerate

  // Registered row and column drives, both active-low.
  always_ff @(posedge clk) begin
    if (!resetn || !enable_reg) begin
      row_n_reg <= '1;
      col_n_reg <= '1;
    end else begin
      row_n_reg <= ~(ROWS'(1) << row);
      col_n_reg <= ~col_on;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: bus reads are scoreboarded
// through an expected-data queue, and a row-0 monitor tallies column duty
// per row visit.
module tb_led_matrix_scanner;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [3:0]  row_n;
  logic [7:0]  col_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];

  typedef struct packed {
    int         c0;
    int         c7;
    int         oth;
    logic [7:0] first;
  } visit_t;

  visit_t visit_q [$];

  localparam logic [31:0] A_FRAME0 = 32'h0400_0000;
  localparam logic [31:0] A_FRAME1 = 32'h0400_0004;
  localparam logic [31:0] A_CTRL   = 32'h0400_0010;
  localparam logic [31:0] A_STATUS = 32'h0400_0014;
  localparam logic [31:0] A_RSVD6  = 32'h0400_0018;

  always #5 clk = ~clk;

  led_matrix_scanner dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .row_n       (row_n),
    .col_n       (col_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transfer; reads pop their expected value when ready arrives.
  task automatic bus_xfer(input string tag, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    int waited;
    logic [31:0] exp;
    waited = 0;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!iomem_ready && waited < 10);
    if (!iomem_ready) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      if (wstrb == 4'b0) void'(exp_q.pop_front());
    end else if (wstrb == 4'b0) begin
      exp = exp_q.pop_front();
      $display("rd %s addr=0x%08h data=0x%08h", tag, addr, iomem_rdata);
      check(tag, iomem_rdata, exp);
    end else begin
      $display("wr %s addr=0x%08h wstrb=%b data=0x%08h", tag, addr, wstrb, wdata);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus_xfer(tag, addr, 4'b0000, 32'h0);
  endtask

  task automatic bus_write(input string tag, input logic [31:0] addr,
                           input logic [3:0] wstrb, input logic [31:0] wdata);
    bus_xfer(tag, addr, wstrb, wdata);
  endtask

  task automatic wait_visits(input int n, input int budget);
    int waited;
    waited = 0;
    while (visit_q.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("visit_wait", 32'(visit_q.size() >= n), 32'd1);
  endtask

  task automatic check_visit(input string tag, input int c0, input int c7);
    visit_t v;
    if (visit_q.size() == 0) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      v = visit_q.pop_front();
      $display("visit %s c0=%0d c7=%0d oth=%0d first=%h", tag, v.c0, v.c7, v.oth, v.first);
      check({tag, "_c0"}, v.c0, c0);
      check({tag, "_c7"}, v.c7, c7);
      check({tag, "_oth"}, v.oth, 0);
      check({tag, "_dead"}, 32'(v.first), 32'hFF);
    end
  endtask

  // Row-0 visit monitor: counts low cycles of col 0, col 7 and the others.
  initial begin
    visit_t cur;
    bit in_row0;
    cur = '0;
    in_row0 = 1'b0;
    forever begin
      @(negedge clk);
      if (row_n == 4'hE) begin
        if (!in_row0) begin
          cur = '0;
          cur.first = col_n;
        end
        if (!col_n[0]) cur.c0 = cur.c0 + 1;
        if (!col_n[7]) cur.c7 = cur.c7 + 1;
        if (col_n[6:1] != 6'h3F) cur.oth = cur.oth + 1;
        in_row0 = 1'b1;
      end else begin
        if (in_row0) visit_q.push_back(cur);
        in_row0 = 1'b0;
      end
    end
  end

  initial begin
    int waited;
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(iomem_ready), 32'd0);
    check("rst_rdata", iomem_rdata, 32'h0);
    check("rst_row_n", 32'(row_n), 32'hF);
    check("rst_col_n", 32'(col_n), 32'hFF);
    resetn = 1'b1;
    @(negedge clk);

    // Reset CTRL value and single-cycle ready pulse.
    bus_read("ctrl_rst", A_CTRL, 32'h002F_0000);
    check("ready_hi", 32'(iomem_ready), 32'd1);
    @(posedge clk);
    #1;
    check("ready_pulse", 32'(iomem_ready), 32'd0);
    @(negedge clk);
    check("idle_row_n", 32'(row_n), 32'hF);
    check("idle_col_n", 32'(col_n), 32'hFF);

    // Two full frames at prescale 0: 128 ticks -> frame 2, row 0.
    bus_write("ctrl_en", A_CTRL, 4'hF, 32'h0000_0001);
    repeat (128) @(negedge clk);
    bus_read("status_2f", A_STATUS, 32'h0002_0000);
    bus_write("ctrl_dis", A_CTRL, 4'hF, 32'h0000_0000);
    check("pre_dis_row_n", 32'(row_n), 32'hE);
    @(negedge clk);
    check("dis_row_n", 32'(row_n), 32'hF);
    check("dis_col_n", 32'(col_n), 32'hFF);
    bus_read("status_dis", A_STATUS, 32'h0002_0000);

    // Duty of row 0 at prescale 0.
    bus_write("frame0_a", A_FRAME0, 4'hF, 32'hF000_0001);
    bus_write("ctrl_en0", A_CTRL, 4'hF, 32'h0000_0001);
    visit_q.delete();
    wait_visits(1, 200);
    check_visit("duty_p0", 1, 15);
    bus_write("ctrl_dis", A_CTRL, 4'hF, 32'h0000_0000);

    // Mid-row frame write is deferred to the next visit of the row.
    bus_write("ctrl_en3", A_CTRL, 4'hF, 32'h0003_0001);
    visit_q.delete();
    waited = 0;
    while (row_n != 4'hE && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (20) @(negedge clk);
    bus_write("frame0_b", A_FRAME0, 4'hF, 32'h0000_0008);
    wait_visits(2, 600);
    check_visit("old_frame", 4, 60);
    check_visit("new_frame", 32, 0);
    bus_write("ctrl_dis", A_CTRL, 4'hF, 32'h0000_0000);

    // Lowering prescale below the running count ticks on the next cycle.
    bus_write("frame0_c", A_FRAME0, 4'hF, 32'h1111_1111);
    bus_write("ctrl_1000", A_CTRL, 4'hF, 32'h03E8_0001);
    repeat (20) @(negedge clk);
    bus_write("ctrl_3", A_CTRL, 4'hF, 32'h0003_0001);
    @(negedge clk);
    check("tick_ph0", 32'(col_n), 32'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tick_ph1", 32'(col_n), 32'h00);
    end
    @(negedge clk);
    check("tick_ph2", 32'(col_n), 32'hFF);
    check("no_restart_row", 32'(row_n), 32'hE);
    bus_write("ctrl_dis", A_CTRL, 4'hF, 32'h0000_0000);

    // Byte strobes, reserved words, CTRL unused bits, address miss.
    bus_write("frame1_full", A_FRAME1, 4'hF, 32'h1234_5678);
    bus_write("frame1_byte", A_FRAME1, 4'b0010, 32'h0000_AB00);
    bus_read("frame1_rb", A_FRAME1, 32'h1234_AB78);
    bus_read("frame0_rb", A_FRAME0, 32'h1111_1111);
    bus_write("rsvd6_wr", A_RSVD6, 4'hF, 32'hDEAD_BEEF);
    bus_read("rsvd6_rb", A_RSVD6, 32'h0);
    bus_write("ctrl_all", A_CTRL, 4'hF, 32'hFFFF_FFFE);
    bus_read("ctrl_rb", A_CTRL, 32'hFFFF_0000);

    iomem_valid = 1'b1;
    iomem_addr  = 32'h0500_0000;
    iomem_wstrb = 4'b0;
    waited = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) waited++;
    end
    iomem_valid = 1'b0;
    $display("rd miss addr=0x05000000 ready_cycles=%0d", waited);
    check("miss_ready", 32'(waited), 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
